// File: rtl/ipl_arb_pkg.sv
// Shared constants for the IPL boot-memory arbiter: default bus widths and port IDs.
package ipl_arb_pkg;

    localparam int IPL_ADDR_W = 12;
    localparam int IPL_DATA_W = 32;
    localparam int IPL_BE_W   = IPL_DATA_W / 8;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // One-hot grant vector for a port ID (bit index == port ID).
    function automatic logic [1:0] port_onehot(input logic port);
        return (port == PORT_B) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with a combinational one-hot grant.
// The 'last' register remembers the most recently served port.
module rr_arbiter2
    import ipl_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last_q;
    logic last_d;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            unique case (req)
                2'b01:   grant = port_onehot(PORT_A);
                2'b10:   grant = port_onehot(PORT_B);
                // On conflict the port that was not served last wins.
                2'b11:   grant = (last_q == PORT_A) ? port_onehot(PORT_B) : port_onehot(PORT_A);
                default: grant = 2'b00;
            endcase
        end
    end

    always_comb begin
        last_d = last_q;
        if (accept && (grant != 2'b00)) begin
            last_d = grant[PORT_B] ? PORT_B : PORT_A;
        end
    end

    // Reset to B so that A wins the first conflict.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_q <= PORT_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ipl_memory_arbiter.sv
// Avalon-MM arbiter sharing the single-port IPL boot RAM between port A (CPU)
// and port B (host/debug loader), with one-cycle registered read return.
module ipl_memory_arbiter
    import ipl_arb_pkg::*;
#(
    parameter int ADDR_W = IPL_ADDR_W,
    parameter int DATA_W = IPL_DATA_W,
    parameter int BE_W   = IPL_BE_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              reset_req,

    input  logic [ADDR_W-1:0] a_address,
    input  logic [BE_W-1:0]   a_byteenable,
    input  logic              a_read,
    input  logic              a_write,
    input  logic [DATA_W-1:0] a_writedata,
    output logic              a_waitrequest,
    output logic [DATA_W-1:0] a_readdata,
    output logic              a_readdatavalid,

    input  logic [ADDR_W-1:0] b_address,
    input  logic [BE_W-1:0]   b_byteenable,
    input  logic              b_read,
    input  logic              b_write,
    input  logic [DATA_W-1:0] b_writedata,
    output logic              b_waitrequest,
    output logic [DATA_W-1:0] b_readdata,
    output logic              b_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    logic [1:0] req;
    logic [1:0] wr;
    logic [1:0] rd_only;
    logic [1:0] grant;
    logic [1:0] rdv_q;
    logic [1:0] rdv_d;
    logic       enable;
    logic       sel_b;
    logic       sel_write;

    // A write wins when read and write are raised together.
    assign wr      = {b_write, a_write};
    assign req     = {b_read | b_write, a_read | a_write};
    assign rd_only = {b_read & ~b_write, a_read & ~a_write};

    assign enable  = reset_n & ~reset_req;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .req     (req),
        .accept  (mem_chipselect),
        .grant   (grant)
    );

    assign a_waitrequest = req[PORT_A] & ~grant[PORT_A];
    assign b_waitrequest = req[PORT_B] & ~grant[PORT_B];

    // Port A drives the RAM bus whenever B is not granted, including idle.
    assign sel_b     = grant[PORT_B];
    assign sel_write = wr[sel_b];

    always_comb begin
        mem_address    = sel_b ? b_address   : a_address;
        mem_writedata  = sel_b ? b_writedata : a_writedata;
        mem_byteenable = '1;
        if (sel_write) begin
            mem_byteenable = sel_b ? b_byteenable : a_byteenable;
        end
    end

    assign mem_chipselect = |grant;
    assign mem_write      = mem_chipselect & sel_write;
    assign mem_clken      = enable;

    always_comb begin
        rdv_d = grant & rd_only;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdv_q <= '0;
        end else begin
            rdv_q <= rdv_d;
        end
    end

    // Masters are reset together with the arbiter, so an in-flight read is
    // dropped as soon as reset_n falls.
    assign a_readdatavalid = rdv_q[PORT_A] & reset_n;
    assign b_readdatavalid = rdv_q[PORT_B] & reset_n;
    assign a_readdata      = mem_readdata;
    assign b_readdata      = mem_readdata;

endmodule

// File: tb/tb_ipl_memory_arbiter.sv
// Directed self-checking bench for ipl_memory_arbiter with a behavioural 4096x32 RAM.
module tb_ipl_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        reset_req = 1'b0;
    logic [11:0] a_address = '0, b_address = '0;
    logic [3:0]  a_byteenable = '0, b_byteenable = '0;
    logic        a_read = 1'b0, a_write = 1'b0, b_read = 1'b0, b_write = 1'b0;
    logic [31:0] a_writedata = '0, b_writedata = '0;
    logic        a_waitrequest, b_waitrequest, a_readdatavalid, b_readdatavalid;
    logic [31:0] a_readdata, b_readdata;
    logic [11:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_readdata;

    logic [31:0] ram [0:4095];
    logic [31:0] ram_q = '0;
    logic        pre_we = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [31:0] pre_data = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ipl_memory_arbiter dut (
        .clk(clk), .reset_n(reset_n), .reset_req(reset_req),
        .a_address(a_address), .a_byteenable(a_byteenable), .a_read(a_read),
        .a_write(a_write), .a_writedata(a_writedata), .a_waitrequest(a_waitrequest),
        .a_readdata(a_readdata), .a_readdatavalid(a_readdatavalid),
        .b_address(b_address), .b_byteenable(b_byteenable), .b_read(b_read),
        .b_write(b_write), .b_writedata(b_writedata), .b_waitrequest(b_waitrequest),
        .b_readdata(b_readdata), .b_readdatavalid(b_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    // Single-port RAM: registered read output that holds while clken is low.
    always @(posedge clk) begin
        if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end else if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int k = 0; k < 4; k++)
                    if (mem_byteenable[k]) ram[mem_address][8*k +: 8] <= mem_writedata[8*k +: 8];
            end else begin
                ram_q <= ram[mem_address];
            end
        end
    end
    assign mem_readdata = ram_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [11:0] addr, input logic [31:0] data);
        pre_we = 1'b1; pre_addr = addr; pre_data = data;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic idle_all();
        a_read = 1'b0; a_write = 1'b0; b_read = 1'b0; b_write = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; a_read = 1'b1; a_address = 12'h000;
        #1;
        checks++; if (a_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_a_wait: got %b want 1", a_waitrequest); end
        checks++; if (b_waitrequest !== 1'b0) begin errors++; $display("FAIL rst_b_wait: got %b want 0", b_waitrequest); end
        checks++; if (mem_clken !== 1'b0) begin errors++; $display("FAIL rst_clken: got %b want 0", mem_clken); end
        checks++; if (mem_chipselect !== 1'b0) begin errors++; $display("FAIL rst_cs: got %b want 0", mem_chipselect); end
        tick();
        checks++; if (a_readdatavalid !== 1'b0 || b_readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_rdv: got %b%b want 00", a_readdatavalid, b_readdatavalid); end
        $display("reset: checked");
        idle_all();
    endtask

    task automatic test_single_read();
        reset_n = 1'b1;
        tick();
        a_read = 1'b1; a_address = 12'h000; a_byteenable = 4'h0;
        #1;
        checks++; if (a_waitrequest !== 1'b0) begin errors++; $display("FAIL sr_wait: got %b want 0", a_waitrequest); end
        checks++; if (mem_chipselect !== 1'b1 || mem_write !== 1'b0) begin errors++; $display("FAIL sr_cs_wr: got %b%b want 10", mem_chipselect, mem_write); end
        checks++; if (mem_byteenable !== 4'hF) begin errors++; $display("FAIL sr_be: got %h want f", mem_byteenable); end
        checks++; if (mem_clken !== 1'b1) begin errors++; $display("FAIL sr_clken: got %b want 1", mem_clken); end
        tick();
        a_read = 1'b0;
        checks++; if (a_readdatavalid !== 1'b1) begin errors++; $display("FAIL sr_rdv: got %b want 1", a_readdatavalid); end
        checks++; if (a_readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sr_data: got %h want deadbeef", a_readdata); end
        checks++; if (b_readdatavalid !== 1'b0) begin errors++; $display("FAIL sr_b_rdv: got %b want 0", b_readdatavalid); end
        tick();
        checks++; if (a_readdatavalid !== 1'b0) begin errors++; $display("FAIL sr_rdv_one: got %b want 0", a_readdatavalid); end
        $display("single_read: addr 000 data %h", 32'hDEADBEEF);
    endtask

    task automatic test_round_robin();
        logic exp_aw, exp_bw;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        a_read = 1'b1; a_address = 12'h001;
        b_read = 1'b1; b_address = 12'h002;
        for (int i = 0; i < 6; i++) begin
            exp_aw = (i % 2) == 1;
            exp_bw = (i % 2) == 0;
            #1;
            checks++; if (a_waitrequest !== exp_aw || b_waitrequest !== exp_bw) begin errors++; $display("FAIL rr_wait[%0d]: got a=%b b=%b want a=%b b=%b", i, a_waitrequest, b_waitrequest, exp_aw, exp_bw); end
            tick();
            checks++; if (a_readdatavalid !== exp_bw || b_readdatavalid !== exp_aw) begin errors++; $display("FAIL rr_rdv[%0d]: got a=%b b=%b want a=%b b=%b", i, a_readdatavalid, b_readdatavalid, exp_bw, exp_aw); end
            checks++; if (mem_readdata !== (exp_bw ? 32'h11111111 : 32'h22222222)) begin errors++; $display("FAIL rr_data[%0d]: got %h want %h", i, mem_readdata, exp_bw ? 32'h11111111 : 32'h22222222); end
            $display("round_robin: cycle %0d granted %s", i, exp_bw ? "A" : "B");
        end
        idle_all();
        tick();
    endtask

    task automatic test_write_read();
        b_write = 1'b1; b_address = 12'h0FF; b_writedata = 32'h12345678; b_byteenable = 4'b0011;
        #1;
        checks++; if (b_waitrequest !== 1'b0 || mem_write !== 1'b1) begin errors++; $display("FAIL wr_grant: got wait=%b wr=%b want 0 1", b_waitrequest, mem_write); end
        checks++; if (mem_byteenable !== 4'b0011 || mem_address !== 12'h0FF) begin errors++; $display("FAIL wr_bus: got be=%b addr=%h want 0011 0ff", mem_byteenable, mem_address); end
        tick();
        b_write = 1'b0;
        checks++; if (b_readdatavalid !== 1'b0) begin errors++; $display("FAIL wr_no_rdv: got %b want 0", b_readdatavalid); end
        a_read = 1'b1; a_address = 12'h0FF;
        tick();
        a_read = 1'b0;
        checks++; if (a_readdatavalid !== 1'b1 || a_readdata !== 32'hAAAA5678) begin errors++; $display("FAIL wr_readback: got rdv=%b data=%h want 1 aaaa5678", a_readdatavalid, a_readdata); end
        $display("write_read: addr 0ff data %h", a_readdata);
    endtask

    task automatic test_reset_req();
        a_read = 1'b1; a_address = 12'h0FF;
        tick();
        reset_req = 1'b1;
        a_read = 1'b1; a_address = 12'h001;
        b_read = 1'b1; b_address = 12'h002;
        #1;
        checks++; if (a_readdatavalid !== 1'b1 || a_readdata !== 32'hAAAA5678) begin errors++; $display("FAIL rq_rdv: got rdv=%b data=%h want 1 aaaa5678", a_readdatavalid, a_readdata); end
        checks++; if (a_waitrequest !== 1'b1 || b_waitrequest !== 1'b1) begin errors++; $display("FAIL rq_wait: got a=%b b=%b want 1 1", a_waitrequest, b_waitrequest); end
        checks++; if (mem_clken !== 1'b0 || mem_chipselect !== 1'b0) begin errors++; $display("FAIL rq_mem: got clken=%b cs=%b want 0 0", mem_clken, mem_chipselect); end
        tick();
        checks++; if (a_readdatavalid !== 1'b0 || b_readdatavalid !== 1'b0) begin errors++; $display("FAIL rq_no_rdv: got a=%b b=%b want 0 0", a_readdatavalid, b_readdatavalid); end
        tick();
        reset_req = 1'b0;
        #1;
        checks++; if (b_waitrequest !== 1'b0 || a_waitrequest !== 1'b1) begin errors++; $display("FAIL rq_b_first: got a=%b b=%b want 1 0", a_waitrequest, b_waitrequest); end
        tick();
        b_read = 1'b0;
        checks++; if (b_readdatavalid !== 1'b1 || b_readdata !== 32'h22222222) begin errors++; $display("FAIL rq_b_data: got rdv=%b data=%h want 1 22222222", b_readdatavalid, b_readdata); end
        #1;
        checks++; if (a_waitrequest !== 1'b0) begin errors++; $display("FAIL rq_a_next: got %b want 0", a_waitrequest); end
        tick();
        a_read = 1'b0;
        checks++; if (a_readdatavalid !== 1'b1 || a_readdata !== 32'h11111111) begin errors++; $display("FAIL rq_a_data: got rdv=%b data=%h want 1 11111111", a_readdatavalid, a_readdata); end
        $display("reset_req: B then A served after release");
    endtask

    task automatic test_read_write_same();
        a_read = 1'b1; a_write = 1'b1; a_address = 12'h010; a_writedata = 32'h00000055; a_byteenable = 4'hF;
        #1;
        checks++; if (mem_write !== 1'b1 || a_waitrequest !== 1'b0) begin errors++; $display("FAIL rw_write: got wr=%b wait=%b want 1 0", mem_write, a_waitrequest); end
        tick();
        a_write = 1'b0;
        checks++; if (a_readdatavalid !== 1'b0) begin errors++; $display("FAIL rw_no_rdv: got %b want 0", a_readdatavalid); end
        tick();
        a_read = 1'b0;
        checks++; if (a_readdatavalid !== 1'b1 || a_readdata !== 32'h00000055) begin errors++; $display("FAIL rw_readback: got rdv=%b data=%h want 1 00000055", a_readdatavalid, a_readdata); end
        $display("read_write_same: addr 010 data %h", a_readdata);
    endtask

    task automatic test_reset_mid_read();
        a_read = 1'b1; a_address = 12'h000;
        tick();
        a_read = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++; if (a_readdatavalid !== 1'b0) begin errors++; $display("FAIL rm_drop: got %b want 0", a_readdatavalid); end
        tick();
        checks++; if (a_readdatavalid !== 1'b0) begin errors++; $display("FAIL rm_drop2: got %b want 0", a_readdatavalid); end
        reset_n = 1'b1;
        a_read = 1'b1; a_address = 12'h000;
        b_read = 1'b1; b_address = 12'h002;
        #1;
        checks++; if (a_waitrequest !== 1'b0 || b_waitrequest !== 1'b1) begin errors++; $display("FAIL rm_a_first: got a=%b b=%b want 0 1", a_waitrequest, b_waitrequest); end
        tick();
        idle_all();
        checks++; if (a_readdatavalid !== 1'b1 || a_readdata !== 32'hDEADBEEF || b_readdatavalid !== 1'b0) begin errors++; $display("FAIL rm_a_data: got rdv=%b data=%h brdv=%b want 1 deadbeef 0", a_readdatavalid, a_readdata, b_readdatavalid); end
        $display("reset_mid_read: A won after release");
        tick();
    endtask

    initial begin
        preload(12'h000, 32'hDEADBEEF);
        preload(12'h001, 32'h11111111);
        preload(12'h002, 32'h22222222);
        preload(12'h0FF, 32'hAAAAAAAA);
        preload(12'h010, 32'h00000000);
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_read();
        test_reset_req();
        test_read_write_same();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
